// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage forwarding, load-use stall and branch flush control
module ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_regwrite,
    input  logic             idex_memread,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_regwrite,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             pc_sel_branch,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   lu_hz;
    logic   br_tk;
    logic   go_stall;
    logic   go_flush;

    // Every compare is ANDed with its enable so X on an idle field stays contained.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic em_hit;
        logic mw_hit;
        em_hit = exmem_regwrite & (exmem_rd != 5'd0) & (exmem_rd == rs);
        mw_hit = memwb_regwrite & (memwb_rd != 5'd0) & (memwb_rd == rs);
        if (em_hit) begin
            return 2'b10;
        end else if (mw_hit) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign lu_hz = id_valid & idex_memread & idex_regwrite & (idex_rd != 5'd0) &
                   ((idex_rd == id_rs1) | (id_uses_rs2 & (idex_rd == id_rs2)));
    assign br_tk = ex_branch & ex_zero;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset_n) begin
            fwd_a = fwd_sel(ex_rs1);
            fwd_b = fwd_sel(ex_rs2);
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_pc      = 1'b0;
        stall_ifid    = 1'b0;
        bubble_idex   = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        pc_sel_branch = 1'b0;
        go_stall      = 1'b0;
        go_flush      = 1'b0;
        case (state)
            RUN: begin
                if (br_tk) begin
                    pc_sel_branch = 1'b1;
                    flush_ifid    = 1'b1;
                    flush_idex    = 1'b1;
                    go_flush      = 1'b1;
                    state_nxt     = FLUSH;
                end else if (lu_hz) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    go_stall    = 1'b1;
                    state_nxt   = LSTALL;
                end
            end
            LSTALL:  state_nxt = RUN;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (!reset_n) begin
            stall_pc      = 1'b0;
            stall_ifid    = 1'b0;
            bubble_idex   = 1'b0;
            flush_ifid    = 1'b0;
            flush_idex    = 1'b0;
            pc_sel_branch = 1'b0;
            go_stall      = 1'b0;
            go_flush      = 1'b0;
            state_nxt     = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (go_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (go_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid, id_uses_rs2, idex_regwrite, idex_memread;
    logic [4:0] id_rs1, id_rs2, idex_rd, ex_rs1, ex_rs2, exmem_rd, memwb_rd;
    logic       ex_branch, ex_zero, exmem_regwrite, memwb_regwrite;

    logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic        stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, pc_sel_branch;
    logic        s_stall_pc, s_stall_ifid, s_bubble_idex, s_flush_ifid, s_flush_idex, s_pc_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ex_hazard_ctrl dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
        .idex_memread(idex_memread), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch(ex_branch),
        .ex_zero(ex_zero), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .pc_sel_branch(pc_sel_branch),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ex_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
        .idex_memread(idex_memread), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch(ex_branch),
        .ex_zero(ex_zero), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .bubble_idex(s_bubble_idex),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .pc_sel_branch(s_pc_sel),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a "cooldown" flag marks the one cycle after any stall or flush start.
    bit cool = 1'b0, cool_n;
    int m_sc = 0, m_fc = 0, m_sc2 = 0, m_fc2 = 0;
    int n_sc, n_fc, n_sc2, n_fc2;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (!reset_n) return 2'b00;
        if (exmem_regwrite === 1'b1 && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
        if (memwb_regwrite === 1'b1 && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clock) begin
        bit lu, br, do_flush, do_stall;
        lu = id_valid && idex_memread && idex_regwrite && idex_rd != 0 &&
             (idex_rd == id_rs1 || (id_uses_rs2 && idex_rd == id_rs2));
        br = ex_branch && ex_zero;
        do_flush = reset_n && !cool && br;
        do_stall = reset_n && !cool && !br && lu;
        chk("m_fwd_a", {30'd0, fwd_a}, {30'd0, m_fwd(ex_rs1)});
        chk("m_fwd_b", {30'd0, fwd_b}, {30'd0, m_fwd(ex_rs2)});
        chk("m_stall", {29'd0, stall_pc, stall_ifid, bubble_idex}, {29'd0, {3{do_stall}}});
        chk("m_flush", {29'd0, pc_sel_branch, flush_ifid, flush_idex}, {29'd0, {3{do_flush}}});
        chk("m_sat_haz", {26'd0, s_stall_pc, s_stall_ifid, s_bubble_idex, s_pc_sel, s_flush_ifid, s_flush_idex},
            {26'd0, {3{do_stall}}, {3{do_flush}}});
        chk("m_sat_fwd", {28'd0, s_fwd_a, s_fwd_b}, {28'd0, m_fwd(ex_rs1), m_fwd(ex_rs2)});
        chk("m_stall_cnt", {16'd0, stall_cnt}, m_sc);
        chk("m_flush_cnt", {16'd0, flush_cnt}, m_fc);
        chk("m_sat_stall_cnt", {30'd0, s_stall_cnt}, m_sc2);
        chk("m_sat_flush_cnt", {30'd0, s_flush_cnt}, m_fc2);
        if (!reset_n) begin
            cool_n = 1'b0; n_sc = 0; n_fc = 0; n_sc2 = 0; n_fc2 = 0;
        end else begin
            cool_n = do_stall || do_flush;
            n_sc  = (do_stall && m_sc  < 65535) ? m_sc + 1  : m_sc;
            n_fc  = (do_flush && m_fc  < 65535) ? m_fc + 1  : m_fc;
            n_sc2 = (do_stall && m_sc2 < 3)     ? m_sc2 + 1 : m_sc2;
            n_fc2 = (do_flush && m_fc2 < 3)     ? m_fc2 + 1 : m_fc2;
        end
    end

    always @(posedge clock) begin
        cool = cool_n; m_sc = n_sc; m_fc = n_fc; m_sc2 = n_sc2; m_fc2 = n_fc2;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        idex_rd = 0; idex_regwrite = 0; idex_memread = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_branch = 0; ex_zero = 0;
        exmem_rd = 0; exmem_regwrite = 0; memwb_rd = 0; memwb_regwrite = 0;
    endtask

    task automatic rand_in();
        id_valid = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        idex_rd = 5'($urandom_range(0, 3)); idex_regwrite = 1'($urandom); idex_memread = 1'($urandom);
        ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
        ex_branch = ($urandom_range(0, 3) == 0); ex_zero = 1'($urandom);
        exmem_rd = 5'($urandom_range(0, 3)); exmem_regwrite = 1'($urandom);
        memwb_rd = 5'($urandom_range(0, 3)); memwb_regwrite = 1'($urandom);
    endtask

    task automatic set_lu();
        idle();
        id_valid = 1; idex_memread = 1; idex_regwrite = 1; idex_rd = 7;
        id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 1;
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        reset_n = 0;
        rand_in();
        // Reset with random inputs
        repeat (2) begin
            @(negedge clock);
            chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
            chk("rst_haz", {26'd0, stall_pc, stall_ifid, bubble_idex, pc_sel_branch, flush_ifid, flush_idex}, 32'd0);
            step();
            rand_in();
        end
        @(negedge clock);
        chk("rst_cnt", {stall_cnt, flush_cnt}, 32'd0);
        step();
        reset_n = 1;
        idle();

        // Forwarding priority and x0
        ex_rs1 = 5; exmem_rd = 5; exmem_regwrite = 1; memwb_rd = 5; memwb_regwrite = 1;
        @(negedge clock);
        chk("fwd_exmem", {30'd0, fwd_a}, 32'd2);
        step();
        exmem_regwrite = 0;
        @(negedge clock);
        chk("fwd_memwb", {30'd0, fwd_a}, 32'd1);
        step();
        ex_rs1 = 0; exmem_rd = 0; memwb_rd = 0; exmem_regwrite = 1; memwb_regwrite = 1;
        ex_rs2 = 9;
        @(negedge clock);
        chk("fwd_x0", {30'd0, fwd_a}, 32'd0);
        chk("fwd_b_none", {30'd0, fwd_b}, 32'd0);
        step();

        // Load-use stall through rs2
        set_lu();
        @(negedge clock);
        chk("lu_stall", {29'd0, stall_pc, stall_ifid, bubble_idex}, 32'd7);
        step();
        @(negedge clock);
        chk("lu_release", {29'd0, stall_pc, stall_ifid, bubble_idex}, 32'd0);
        chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        step();
        id_uses_rs2 = 0;
        @(negedge clock);
        chk("lu_no_rs2", {31'd0, stall_pc}, 32'd0);
        step();

        // Taken branch beats a simultaneous load-use
        id_uses_rs2 = 1; ex_branch = 1; ex_zero = 1;
        @(negedge clock);
        chk("br_flush", {28'd0, pc_sel_branch, flush_ifid, flush_idex, stall_pc}, 32'he);
        step();
        @(negedge clock);
        chk("br_after", {28'd0, pc_sel_branch, flush_ifid, flush_idex, stall_pc}, 32'd0);
        chk("br_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
        step();
        ex_zero = 0; id_valid = 0;
        @(negedge clock);
        chk("br_not_taken", {31'd0, pc_sel_branch}, 32'd0);
        step();

        // Saturation on the 2-bit instance
        reset_n = 0;
        step();
        reset_n = 1;
        set_lu();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("sat_stall", {31'd0, s_stall_pc}, 32'd1);
            step();
            @(negedge clock);
            chk("sat_cnt", {30'd0, s_stall_cnt}, sat_exp[k]);
            step();
        end

        // Reset while a stall sequence is in flight
        @(negedge clock);
        chk("mid_stall", {31'd0, stall_pc}, 32'd1);
        step();
        reset_n = 0;
        @(negedge clock);
        chk("mid_rst_forced", {29'd0, stall_pc, stall_ifid, bubble_idex}, 32'd0);
        step();
        reset_n = 1;
        @(negedge clock);
        chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_fresh_stall", {31'd0, stall_pc}, 32'd1);
        step();
        @(negedge clock);
        chk("mid_fresh_cnt", {16'd0, stall_cnt}, 32'd1);
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_in();
            reset_n = ($urandom_range(0, 49) != 0);
            step();
        end
        reset_n = 1;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
